keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix keypad input peripheral; the input-side counterpart of the 7-seg display driver.
//  Drives active-low rows one at a time and samples the active-low columns.
//  Debounces per full scan frame and holds one accepted key code.
//  The CPU polls it through a 32-bit read port.
// PARAMETERS
//  SCAN_TICKS      4999  row dwell = SCAN_TICKS+1 clk cycles; frame = 4*(SCAN_TICKS+1)
//  DEBOUNCE_SCANS  4     consecutive agreeing frames needed to accept a press/release (>=1)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset, asynchronous, active-low
//  col_in       in   4   keypad columns, active-low (pulled up), asynchronous
//  row_out      out  4   keypad row drive, active-low, exactly one bit low
//  rd_en        in   1   one-cycle read strobe; consumes pending key
//  rdata        out  32  status/key word (see below), combinational from registers
//  key_pending  out  1   accepted key not yet read (= rdata[31])
// BEHAVIOUR
//  Reset values:
//   - row_out=4'b1110, tick=0, col sync FFs=4'hF, FSM=IDLE
//   - key_code=0, key_pending=0, overrun=0 -> rdata=0
//  Input sync: col_in -> 2-FF synchronizer before use.
//  Scan:
//   - tick counts 0..SCAN_TICKS and wraps to 0.
//   - On tick==SCAN_TICKS: latch synced cols for the current row, and rotate row_out left
//     at the same edge (1110->1101->1011->0111->1110).
//   - Sampling row3 (0111) closes a frame.
//  Frame result:
//   - Count low column bits over all 4 rows.
//   - 0 -> NONE; exactly 1 -> KEY k = row_idx*4+col_idx (bit index of the low bit);
//     >=2 -> MULTI (ghost).
//  FSM, evaluated once per frame end; cnt counts frames:
//   - IDLE: KEY k -> PRESS_DEB, cand=k, cnt=1; else stay.
//   - PRESS_DEB: KEY==cand -> cnt++; NONE -> IDLE; MULTI -> stay, cnt held.
//     KEY!=cand -> cand=k, cnt=1.
//     When cnt reaches DEBOUNCE_SCANS -> ACCEPT, HELD.
//     DEBOUNCE_SCANS=1: accept on the first KEY frame, direct from IDLE.
//   - HELD: NONE -> RELEASE_DEB, cnt=1; KEY/MULTI -> stay (no auto-repeat).
//   - RELEASE_DEB: NONE -> cnt++, at DEBOUNCE_SCANS -> IDLE. KEY/MULTI -> HELD.
//  ACCEPT: key_code<=cand, key_pending<=1; overrun<=1 if key_pending was already 1 (newest wins).
//  Read:
//   - rd_en clears key_pending and overrun at the next edge.
//   - rd_en coincident with ACCEPT: key_pending=1, key_code=new, overrun=0.
//  rdata map:
//   - [31]=key_pending, [30]=overrun, [29:5]=0
//   - [4]=held (FSM in HELD or RELEASE_DEB), [3:0]=key_code
//  Latency: stable press from frame start -> ACCEPT at end of the DEBOUNCE_SCANS-th frame,
//   plus 1 cycle to rdata.
//  Async reset mid-operation: all state returns to reset values immediately; no partial accept.
// TESTING (sim params SCAN_TICKS=3, DEBOUNCE_SCANS=2)
//  1 Reset, col_in=F -> row_out=1110 and rotates every 4 clks; rdata stays 0 for 10 frames.
//  2 Hold row2/col1 (col_in[1] low while row_out=1011) 3 frames -> after frame 2 rdata=0x8000_0019.
//    Release 2 frames -> rdata=0x8000_0009.
//  3 Bounce: key 9 for 1 frame, NONE 1 frame, repeated 5 times -> key_pending never 1.
//  4 Accept key 9, no read, accept key 3 -> rdata=0xC000_0003 (held=0 after release).
//    Then pulse rd_en -> rdata=0x0000_0003.
//  5 rd_en on the ACCEPT cycle of key 5 after unread key 9 -> rdata[31]=1, [30]=0, [3:0]=5.
//  6 Keys 0 and 6 together 4 frames -> no accept. Assert rst_n=0 mid PRESS_DEB -> rdata=0,
//    row_out=1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-frame debounce and a polled 32-bit read port
module keypad_scanner #(
  parameter int SCAN_TICKS     = 4999,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        key_pending
);
  localparam int TW = SCAN_TICKS > 0 ? $clog2(SCAN_TICKS + 1) : 1;
  localparam int CW = DEBOUNCE_SCANS > 1 ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick;
  logic [1:0] row_idx, acc_n, fr_n, col_idx;
  logic [3:0] c1, c2, acc_key, fr_key, cand, cand_nx, key_code;
  logic [2:0] low_n, sum_n;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic tick_end, frame_end, is_none, is_key, accept, overrun, held;
  assign tick_end  = tick == TW'(SCAN_TICKS);
  assign frame_end = tick_end && row_idx == 2'd3;
  assign row_out   = ~(4'b0001 << row_idx);
  assign low_n     = 3'(!c2[0]) + 3'(!c2[1]) + 3'(!c2[2]) + 3'(!c2[3]);
  assign col_idx   = !c2[0] ? 2'd0 : !c2[1] ? 2'd1 : !c2[2] ? 2'd2 : 2'd3;
  assign sum_n     = {1'b0, acc_n} + low_n;
  assign fr_n      = sum_n >= 3'd2 ? 2'd2 : sum_n[1:0];
  assign fr_key    = acc_n == 2'd0 ? {row_idx, col_idx} : acc_key;
  assign is_none   = fr_n == 2'd0;
  assign is_key    = fr_n == 2'd1;
  assign cnt_inc   = cnt + 1'b1;
  assign held      = state == HELD || state == RELEASE_DEB;
  assign rdata     = {key_pending, overrun, 25'b0, held, key_code};
  // two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {c1, c2} <= 8'hFF;
    else {c1, c2} <= {col_in, c1};
  // row dwell counter, row rotation and per-frame accumulation of low columns (saturating at two)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tick    <= '0;
      row_idx <= 2'd0;
      acc_n   <= 2'd0;
      acc_key <= 4'd0;
    end else begin
      tick <= tick_end ? '0 : tick + 1'b1;
      if (tick_end) begin
        row_idx <= row_idx + 1'b1;
        acc_n   <= frame_end ? 2'd0 : fr_n;
        acc_key <= frame_end ? 4'd0 : fr_key;
      end
    end
  // debounce state, candidate key and agreeing-frame count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  // debounce transitions, evaluated only on the frame-closing edge
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    accept   = 1'b0;
    if (frame_end)
      case (state)
        IDLE:
          if (is_key) begin
            cand_nx  = fr_key;
            cnt_nx   = CW'(1);
            accept   = DEB == CW'(1);
            state_nx = accept ? HELD : PRESS_DEB;
          end
        PRESS_DEB:
          if (is_none) state_nx = IDLE;
          else if (is_key) begin
            if (fr_key != cand) begin
              cand_nx = fr_key;
              cnt_nx  = CW'(1);
            end else if (cnt_inc >= DEB) begin
              accept   = 1'b1;
              state_nx = HELD;
            end else cnt_nx = cnt_inc;
          end
        HELD:
          if (is_none) begin
            cnt_nx   = CW'(1);
            state_nx = DEB == CW'(1) ? IDLE : RELEASE_DEB;
          end
        RELEASE_DEB:
          if (!is_none) state_nx = HELD;
          else if (cnt_inc >= DEB) state_nx = IDLE;
          else cnt_nx = cnt_inc;
        default: state_nx = IDLE;
      endcase
  end
  // accepted key register; a read clears pending/overrun unless a new key lands on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_code    <= 4'd0;
      key_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      key_code    <= accept ? cand_nx : key_code;
      key_pending <= accept | (key_pending & ~rd_en);
      overrun     <= accept ? key_pending & ~rd_en : overrun & ~rd_en;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, accept/read and reset of keypad_scanner
module tb_keypad_scanner;
  logic clk = 1'b0, rst_n = 1'b0, rd_en = 1'b0, key_pending;
  logic [3:0] col_in, row_out;
  logic [31:0] rdata;
  logic [15:0] keys = 16'h0;
  int n_cmp = 0, n_err = 0;
  keypad_scanner #(.SCAN_TICKS(3), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .rd_en(rd_en), .rdata(rdata), .key_pending(key_pending)
  );
  // clock
  always #5 clk = ~clk;
  // keypad model: a pressed key shorts its column low while its row is driven low
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r]) col_in = col_in & ~keys[r*4 +: 4];
  end
  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (row_out != r && n < 64);
    if (n >= 64) check("row_timeout", {28'h0, row_out}, {28'h0, r});
  endtask
  task automatic wait_frame();
    wait_row(4'b0111);
    wait_row(4'b1110);
  endtask
  task automatic frames(input int n);
    repeat (n) wait_frame();
  endtask
  task automatic read_pulse();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_row", {28'h0, row_out}, 32'hE);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("row0_dwell", {28'h0, row_out}, 32'hE);
    @(posedge clk);
    #1 check("row1", {28'h0, row_out}, 32'hD);
    repeat (4) @(posedge clk);
    #1 check("row2", {28'h0, row_out}, 32'hB);
    for (int i = 0; i < 10; i++) begin
      wait_frame();
      check("idle_rdata", rdata, 32'h0);
    end
    keys = 16'h0200;
    wait_frame();
    check("k9_frame1", rdata, 32'h0);
    wait_frame();
    check("k9_accept", rdata, 32'h8000_0019);
    wait_frame();
    check("k9_held", rdata, 32'h8000_0019);
    keys = 16'h0;
    wait_frame();
    check("k9_rel1", rdata, 32'h8000_0019);
    wait_frame();
    check("k9_rel2", rdata, 32'h8000_0009);
    read_pulse();
    check("k9_read", rdata, 32'h0000_0009);
    for (int i = 0; i < 5; i++) begin
      keys = 16'h0200;
      wait_frame();
      check("bounce_on", {31'h0, key_pending}, 32'h0);
      keys = 16'h0;
      wait_frame();
      check("bounce_off", {31'h0, key_pending}, 32'h0);
    end
    keys = 16'h0200;
    frames(2);
    check("ovr_k9", rdata, 32'h8000_0019);
    keys = 16'h0;
    frames(2);
    keys = 16'h0008;
    frames(2);
    check("ovr_k3", rdata, 32'hC000_0013);
    keys = 16'h0;
    frames(2);
    check("ovr_rel", rdata, 32'hC000_0003);
    read_pulse();
    check("ovr_read", rdata, 32'h0000_0003);
    keys = 16'h0200;
    frames(2);
    keys = 16'h0;
    frames(2);
    check("pre_k5", rdata, 32'h8000_0009);
    keys = 16'h0020;
    wait_frame();
    wait_row(4'b0111);
    repeat (3) @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    check("rdacc_row", {28'h0, row_out}, 32'hE);
    check("rdacc_rdata", rdata, 32'h8000_0015);
    keys = 16'h0;
    frames(2);
    read_pulse();
    check("k5_read", rdata, 32'h0000_0005);
    keys = 16'h0041;
    for (int i = 0; i < 4; i++) begin
      wait_frame();
      check("ghost", rdata, 32'h0000_0005);
    end
    keys = 16'h0040;
    wait_frame();
    check("k6_deb", rdata, 32'h0000_0005);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_rdata", rdata, 32'h0);
    check("arst_row", {28'h0, row_out}, 32'hE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    check("post_rst_f1", {31'h0, key_pending}, 32'h0);
    wait_frame();
    check("post_rst_k6", rdata, 32'h8000_0016);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
